// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Package : mem_stage_pkg - memory-stage FSM state and write-back source select
// Revision: 1.0
// ============================================================================
package mem_stage_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_t;

  localparam logic [1:0] c_wb_src_none = 2'd0;
  localparam logic [1:0] c_wb_src_alu  = 2'd1;
  localparam logic [1:0] c_wb_src_mem  = 2'd2;

  // A simultaneous read+write is treated as a store, so write-back falls back to the ALU path.
  function automatic logic [1:0] wb_src(input logic sel_alu, input logic sel_mem,
                                        input logic rd_wr_conflict);
    if (rd_wr_conflict)  return c_wb_src_alu;
    else if (sel_mem)    return c_wb_src_mem;
    else if (sel_alu)    return c_wb_src_alu;
    else                 return c_wb_src_none;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
// Module  : data_mem - data memory, synchronous write, asynchronous read, range guarded
// Revision: 1.0
// ============================================================================
module data_mem #(
  parameter int WORD_LEN  = 8,
  parameter int ADDR_LEN  = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [ADDR_LEN-1:0] i_addr,
  input  logic [WORD_LEN-1:0] i_wdata,
  output logic [WORD_LEN-1:0] o_rdata
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [WORD_LEN-1:0] r_mem [MEM_DEPTH];
  logic                w_in_range;
  logic [IDX_W-1:0]    w_idx;

  assign w_in_range = ({1'b0, i_addr} < (ADDR_LEN + 1)'(MEM_DEPTH));
  assign w_idx      = i_addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (i_we && w_in_range) r_mem[w_idx] <= i_wdata;
  end

  assign o_rdata = w_in_range ? r_mem[w_idx] : '0;

endmodule
`default_nettype wire

// File: rtl/pr4_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : pr4_mem_wb_stage - memory stage with multi-cycle access and MEM/WB register
// Revision: 1.0
// ============================================================================
module pr4_mem_wb_stage
  import mem_stage_pkg::*;
#(
  parameter int WORD_LEN    = 8,
  parameter int INSTR_LEN   = 19,
  parameter int ADDR_LEN    = 8,
  parameter int MEM_DEPTH   = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PR3_valid,
  input  logic [INSTR_LEN-1:0] PR3_instruction,
  input  logic [WORD_LEN-1:0]  PR3_alu_out,
  input  logic [WORD_LEN-1:0]  PR3_store_data,
  input  logic [2:0]           PR3_dest_reg,
  input  logic                 PR3_MEM_read,
  input  logic                 PR3_MEM_write,
  input  logic                 PR3_sel_RF_write_src_ALU,
  input  logic                 PR3_sel_RF_write_src_MEM,
  input  logic                 PR3_RF_write_en,
  output logic                 stall,
  output logic                 PR4_valid,
  output logic [INSTR_LEN-1:0] PR4_instruction,
  output logic [WORD_LEN-1:0]  PR4_wb_data,
  output logic [2:0]           PR4_dest_reg,
  output logic                 PR4_RF_write_en,
  output logic                 mem_conflict
);

  localparam int            CW            = $clog2(MEM_LATENCY) + 1;
  localparam logic [CW-1:0] c_cnt_load    = CW'(MEM_LATENCY - 1);
  localparam logic [CW-1:0] c_cnt_last    = CW'(1);
  localparam bit            c_multi_cycle = (MEM_LATENCY > 1);

  mem_state_t           r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_valid;
  logic [INSTR_LEN-1:0] r_instr;
  logic [WORD_LEN-1:0]  r_wb_data;
  logic [2:0]           r_dest;
  logic                 r_rf_we;
  logic                 r_conflict;

  logic                 w_mem_op;
  logic                 w_rd_wr_conflict;
  logic                 w_complete;
  logic                 w_stall;
  logic                 w_mem_we;
  logic [WORD_LEN-1:0]  w_mem_rdata;
  logic [WORD_LEN-1:0]  w_wb_data;

  assign w_mem_op         = PR3_valid & (PR3_MEM_read | PR3_MEM_write);
  assign w_rd_wr_conflict = w_mem_op & PR3_MEM_read & PR3_MEM_write;

  // Completion edge: any idle non-memory cycle, a single-cycle access, or the last access cycle.
  always_comb begin
    w_complete = 1'b0;
    w_stall    = 1'b0;
    if (r_state == ST_IDLE) begin
      w_complete = !w_mem_op || !c_multi_cycle;
      w_stall    = w_mem_op && c_multi_cycle;
    end else begin
      w_complete = (r_cnt == c_cnt_last);
      w_stall    = (r_cnt > c_cnt_last);
    end
  end

  // Reset must drop stall at once even while upstream still presents a memory op.
  assign stall    = w_stall & ~rst;
  assign w_mem_we = w_complete & w_mem_op & PR3_MEM_write & ~rst;

  data_mem #(
    .WORD_LEN (WORD_LEN),
    .ADDR_LEN (ADDR_LEN),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_data_mem (
    .clk    (clk),
    .i_we   (w_mem_we),
    .i_addr (PR3_alu_out[ADDR_LEN-1:0]),
    .i_wdata(PR3_store_data),
    .o_rdata(w_mem_rdata)
  );

  always_comb begin
    w_wb_data = '0;
    case (wb_src(PR3_sel_RF_write_src_ALU, PR3_sel_RF_write_src_MEM, w_rd_wr_conflict))
      c_wb_src_mem: w_wb_data = w_mem_rdata;
      c_wb_src_alu: w_wb_data = PR3_alu_out;
      default:      w_wb_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_wb_data  <= '0;
      r_dest     <= '0;
      r_rf_we    <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mem_op && c_multi_cycle) begin
            r_state <= ST_ACCESS;
            r_cnt   <= c_cnt_load;
          end
        end
        ST_ACCESS: begin
          r_cnt <= r_cnt - c_cnt_last;
          if (r_cnt == c_cnt_last) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_complete) begin
        r_valid   <= PR3_valid;
        r_instr   <= PR3_instruction;
        r_wb_data <= w_wb_data;
        r_dest    <= PR3_dest_reg;
        r_rf_we   <= PR3_valid & PR3_RF_write_en;
      end else if (r_state == ST_IDLE) begin
        r_valid   <= 1'b0;
        r_instr   <= '0;
        r_wb_data <= '0;
        r_dest    <= '0;
        r_rf_we   <= 1'b0;
      end

      if (w_complete && w_rd_wr_conflict) r_conflict <= 1'b1;
    end
  end

  assign PR4_valid       = r_valid;
  assign PR4_instruction = r_instr;
  assign PR4_wb_data     = r_wb_data;
  assign PR4_dest_reg    = r_dest;
  assign PR4_RF_write_en = r_rf_we;
  assign mem_conflict    = r_conflict;

endmodule
`default_nettype wire
